issue_operand_fetch: RTL and testbench

Operand-fetch stage directly downstream of `issue_prf`, between the issue queue and execute. It accepts one issued micro-op per cycle and drives its two source physical-register addresses onto the PRF read ports B and C. It merges the read data with a same-cycle writeback bypass taken from PRF write port A. The result is presented to execute through a registered valid/ready output backed by a one-entry skid buffer.

---
 rtl/issue_operand_fetch.sv | 111 +++++++++++
 tb/tb_issue_operand_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/issue_operand_fetch.sv
// Operand-fetch stage: drives PRF read addresses, merges a same-cycle writeback bypass and
// presents the op to execute through a registered output backed by a one-entry skid buffer.
module issue_operand_fetch #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned TAG_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [ADDR_W-1:0] in_src1,
  input  logic [ADDR_W-1:0] in_src2,
  input  logic [ADDR_W-1:0] in_dst,
  output logic [ADDR_W-1:0] prf_addrb,
  output logic [ADDR_W-1:0] prf_addrc,
  input  logic [DATA_W-1:0] prf_doutb,
  input  logic [DATA_W-1:0] prf_doutc,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [ADDR_W-1:0] out_dst,
  output logic [DATA_W-1:0] out_src1_data,
  output logic [DATA_W-1:0] out_src2_data
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] src1_data;
    logic [DATA_W-1:0] src2_data;
  } op_t;

  op_t  new_op;
  op_t  out_q, out_d;
  op_t  skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic drain;
  logic accept;

  assign prf_addrb = in_src1;
  assign prf_addrc = in_src2;

  // PRF is not write-through, so a source written this cycle must come from the bypass.
  always_comb begin
    new_op.tag       = in_tag;
    new_op.dst       = in_dst;
    new_op.src1_data = (wb_we && (wb_addr == in_src1)) ? wb_data : prf_doutb;
    new_op.src2_data = (wb_we && (wb_addr == in_src2)) ? wb_data : prf_doutc;
  end

  assign in_ready = !skid_valid_q;
  assign drain    = out_valid_q && out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) begin
      if (drain) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || drain) begin
        out_d       = new_op;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = new_op;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
    // Flush only kills valids; any drain this cycle has already completed for execute.
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_tag       = out_q.tag;
  assign out_dst       = out_q.dst;
  assign out_src1_data = out_q.src1_data;
  assign out_src2_data = out_q.src2_data;

endmodule

// File: tb/tb_issue_operand_fetch.sv
// Scoreboard bench for issue_operand_fetch: the driver pushes expected ops on accept, a
// negedge monitor pops and compares on every output handshake and checks stall stability.
module tb_issue_operand_fetch;

  localparam int OPW = 8 + 6 + 64 + 64;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [7:0]  in_tag;
  logic [5:0]  in_src1, in_src2, in_dst, prf_addrb, prf_addrc, wb_addr;
  logic [63:0] prf_doutb, prf_doutc, wb_data;
  logic        wb_we, out_valid, out_ready;
  logic [7:0]  out_tag;
  logic [5:0]  out_dst;
  logic [63:0] out_src1_data, out_src2_data;

  logic [63:0]    prf [64];
  logic [OPW-1:0] sb[$];
  logic [OPW-1:0] cur_exp;
  logic [OPW:0]   prev_snap;
  logic           prev_held = 1'b0;
  int             pass_cnt = 0;
  int             total_cnt = 0;

  always #5 clk = ~clk;

  assign prf_doutb = prf[prf_addrb];
  assign prf_doutc = prf[prf_addrc];

  issue_operand_fetch #(.ADDR_W(6), .DATA_W(64), .TAG_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_tag        (in_tag),
    .in_src1       (in_src1),
    .in_src2       (in_src2),
    .in_dst        (in_dst),
    .prf_addrb     (prf_addrb),
    .prf_addrc     (prf_addrc),
    .prf_doutb     (prf_doutb),
    .prf_doutc     (prf_doutc),
    .wb_we         (wb_we),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_tag       (out_tag),
    .out_dst       (out_dst),
    .out_src1_data (out_src1_data),
    .out_src2_data (out_src2_data)
  );

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_op(input logic [7:0] tag, input logic [5:0] s1, input logic [5:0] s2,
                        input logic [5:0] dst, input logic [63:0] e1, input logic [63:0] e2);
    in_valid = 1'b1;
    in_tag   = tag;
    in_src1  = s1;
    in_src2  = s2;
    in_dst   = dst;
    cur_exp  = {tag, dst, e1, e2};
  endtask

  // One cycle: record the expected op if the handshake happens at the coming edge.
  task automatic step();
    @(negedge clk);
    if (in_valid && in_ready && !flush && !reset) sb.push_back(cur_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_held)
        chk("hold_stable", {out_valid, out_tag, out_dst, out_src1_data, out_src2_data},
            prev_snap);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_out: got tag %0h with no op expected", out_tag);
        end else begin
          chk("out_op", {out_tag, out_dst, out_src1_data, out_src2_data}, sb.pop_front());
        end
      end
    end
    prev_held = out_valid && !out_ready && !reset && !flush;
    prev_snap = {out_valid, out_tag, out_dst, out_src1_data, out_src2_data};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) prf[i] = 64'h1000 + 64'(i);
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_tag = '0; in_src1 = '0; in_src2 = '0; in_dst = '0; cur_exp = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", {out_tag, out_dst, out_src1_data, out_src2_data}, 0);

    // Streaming
    set_op(8'd1, 6'd3, 6'd4, 6'd10, 64'h1003, 64'h1004);
    chk("addrb", prf_addrb, 3);
    chk("addrc", prf_addrc, 4);
    step();
    chk("stream_ready1", in_ready, 1);
    set_op(8'd2, 6'd5, 6'd5, 6'd11, 64'h1005, 64'h1005);
    step();
    chk("stream_ready2", in_ready, 1);
    idle(2);

    // Bypass
    wb_we = 1'b1; wb_addr = 6'd7; wb_data = 64'hDEAD;
    set_op(8'h20, 6'd7, 6'd9, 6'd13, 64'hDEAD, 64'h1009);
    step();
    wb_addr = 6'd9;
    set_op(8'h21, 6'd7, 6'd9, 6'd14, 64'h1007, 64'hDEAD);
    step();
    set_op(8'h22, 6'd9, 6'd9, 6'd15, 64'hDEAD, 64'hDEAD);
    step();
    wb_we = 1'b0;
    idle(2);

    // Backpressure: A to OUT, B to SKID, C refused until SKID empties
    out_ready = 1'b0;
    set_op(8'hA0, 6'd1, 6'd2, 6'd20, 64'h1001, 64'h1002);
    step();
    set_op(8'hB0, 6'd3, 6'd6, 6'd21, 64'h1003, 64'h1006);
    step();
    set_op(8'hC0, 6'd8, 6'd10, 6'd22, 64'h1008, 64'h100A);
    chk("c_blocked", in_ready, 0);
    step();
    out_ready = 1'b1;
    chk("c_blocked_drain", in_ready, 0);
    step();
    chk("ready_recovered", in_ready, 1);
    step();
    idle(2);

    // Stall stability while the PRF changes under the held op
    out_ready = 1'b0;
    set_op(8'h30, 6'd3, 6'd4, 6'd12, 64'h1003, 64'h1004);
    step();
    in_valid = 1'b0;
    prf[3] = 64'h5555;
    repeat (5) step();
    chk("stall_valid", out_valid, 1);
    chk("stall_src1", out_src1_data, 64'h1003);
    out_ready = 1'b1;
    idle(2);
    prf[3] = 64'h1003;

    // Flush with both registers full and an op offered
    out_ready = 1'b0;
    set_op(8'h40, 6'd1, 6'd1, 6'd30, 64'h1001, 64'h1001);
    step();
    set_op(8'h41, 6'd2, 6'd2, 6'd31, 64'h1002, 64'h1002);
    step();
    chk("skid_full", in_ready, 0);
    step();
    set_op(8'h42, 6'd4, 6'd4, 6'd32, 64'h1004, 64'h1004);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    idle(3);

    // Reset mid-operation
    out_ready = 1'b0;
    set_op(8'h50, 6'd5, 6'd6, 6'd33, 64'h1005, 64'h1006);
    step();
    set_op(8'h51, 6'd7, 6'd8, 6'd34, 64'h1007, 64'h1008);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_data", {out_tag, out_dst, out_src1_data, out_src2_data}, 0);
    idle(3);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
